// File: rtl/hilo_div_seq.sv
// Iterative radix-2 restoring divider that sequences the EX-stage HI/LO write
// port for DIV/DIVU. Holds the pipeline while it runs, then emits one write
// pulse carrying {remainder, quotient}.
module hilo_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opdata1,
    input  logic [WIDTH-1:0] opdata2,
    input  logic             annul,
    output logic             stall_req,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;

    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] trial;
    logic             no_borrow;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    // Operand magnitudes and one restoring step (shift, trial subtract, restore).
    always_comb begin
        abs1      = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
        abs2      = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        trial     = {1'b0, rem_shift} - {2'b00, dvs_q};
        no_borrow = ~trial[WIDTH+1];
        step_rem  = no_borrow ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        step_quo  = {dvd_q[WIDTH-2:0], no_borrow};
    end

    // Next-state and datapath update; annul overrides everything and keeps results.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    neg_quo_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    neg_rem_d = signed_div & opdata1[WIDTH-1];
                    dvs_d     = abs2;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (opdata2 == '0) begin
                        state_d = ZERO;
                        dvd_d   = opdata1;
                    end else begin
                        state_d = RUN;
                        dvd_d   = abs1;
                    end
                end
            end
            ZERO: begin
                state_d  = DONE;
                res_lo_d = '1;
                res_hi_d = dvd_q;
            end
            RUN: begin
                rem_d = step_rem;
                dvd_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    res_lo_d = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
                    res_hi_d = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (annul) begin
            state_d  = IDLE;
            cnt_d    = '0;
            res_hi_d = res_hi_q;
            res_lo_d = res_lo_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
        end
    end

    // Status outputs; a kill in the DONE cycle squashes the HI/LO write.
    always_comb begin
        busy         = (state_q != IDLE);
        result_valid = (state_q == DONE) & ~annul;
        stall_req    = ~annul & (((state_q == IDLE) & start) | (state_q == ZERO) | (state_q == RUN));
        result_hi    = res_hi_q;
        result_lo    = res_lo_q;
    end

endmodule

// File: tb/tb_hilo_div_seq.sv
// Self-checking bench for hilo_div_seq: directed cases with literal results
// plus randomized traffic compared every cycle against a countdown model.
module tb_hilo_div_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        stall_req;
    logic        busy;
    logic        result_valid;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

    int total = 0;
    int bad   = 0;
    bit check_en = 0;

    bit          m_active = 0;
    int          m_wait = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;

    logic        obs_stall, obs_busy, obs_valid;
    logic [31:0] obs_hi, obs_lo;

    hilo_div_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_div  (signed_div),
        .opdata1     (opdata1),
        .opdata2     (opdata2),
        .annul       (annul),
        .stall_req   (stall_req),
        .busy        (busy),
        .result_valid(result_valid),
        .result_hi   (result_hi),
        .result_lo   (result_lo)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural divide result: plain arithmetic plus the two special cases.
    function automatic void ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
        int sa;
        int sb;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (sd) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lo = 32'h8000_0000;
                hi = 32'd0;
            end else begin
                sa = a;
                sb = b;
                lo = sa / sb;
                hi = sa % sb;
            end
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every output against the model for the current cycle.
    task automatic checkOutput();
        logic e_stall, e_valid;
        e_stall = !annul && ((!m_active && start) || (m_active && m_wait > 0));
        e_valid = m_active && (m_wait == 0) && !annul;
        checkOne("busy", {31'd0, obs_busy}, {31'd0, m_active});
        checkOne("stall_req", {31'd0, obs_stall}, {31'd0, e_stall});
        checkOne("result_valid", {31'd0, obs_valid}, {31'd0, e_valid});
        checkOne("result_hi", obs_hi, m_hi);
        checkOne("result_lo", obs_lo, m_lo);
    endtask

    // Advance the model across one clock edge using the inputs seen at that edge.
    task automatic modelUpdate();
        if (rst) begin
            m_active = 0;
            m_hi     = '0;
            m_lo     = '0;
        end else if (annul) begin
            m_active = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1;
                m_wait   = (opdata2 == 32'd0) ? 1 : 32;
                ref_div(signed_div, opdata1, opdata2, p_hi, p_lo);
            end
        end else if (m_wait == 0) begin
            m_active = 0;
        end else begin
            m_wait--;
            if (m_wait == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end
    endtask

    task automatic applyStimulus(input logic s, input logic sd, input logic [31:0] a,
                                 input logic [31:0] b, input logic an);
        start      = s;
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        annul      = an;
    endtask

    // One cycle: sample at the falling edge, check, then cross the rising edge.
    task automatic step();
        @(negedge clk);
        obs_stall = stall_req;
        obs_busy  = busy;
        obs_valid = result_valid;
        obs_hi    = result_hi;
        obs_lo    = result_lo;
        if (check_en) checkOutput();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    // Issue one divide from IDLE and pin its latency, stall length and values.
    task automatic runDirected(input string name, input logic sd, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_lo,
                               input logic [31:0] exp_hi, input int exp_lat);
        int seen;
        int stalls;
        logic [31:0] got_lo, got_hi;
        seen   = -1;
        stalls = 0;
        got_lo = '0;
        got_hi = '0;
        applyStimulus(1'b1, sd, a, b, 1'b0);
        for (int c = 0; c < 40 && seen < 0; c++) begin
            step();
            if (obs_stall) stalls++;
            if (obs_valid) begin
                seen   = c;
                got_lo = obs_lo;
                got_hi = obs_hi;
            end
            applyStimulus(1'b0, ~sd, $urandom, $urandom, 1'b0);
        end
        checkOne({name, " latency"}, 32'(seen), 32'(exp_lat));
        checkOne({name, " stall cycles"}, 32'(stalls), 32'(exp_lat));
        checkOne({name, " lo"}, got_lo, exp_lo);
        checkOne({name, " hi"}, got_hi, exp_hi);
        step();
        checkOne({name, " busy after"}, {31'd0, obs_busy}, 32'd0);
    endtask

    initial begin
        int valids;
        logic [31:0] a, b;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step();
        rst      = 1'b0;
        check_en = 1;

        // Reset state.
        step();
        checkOne("reset busy", {31'd0, obs_busy}, 32'd0);
        checkOne("reset stall", {31'd0, obs_stall}, 32'd0);
        checkOne("reset valid", {31'd0, obs_valid}, 32'd0);
        checkOne("reset hi", obs_hi, 32'd0);
        checkOne("reset lo", obs_lo, 32'd0);

        // Directed divides with hand-computed results.
        runDirected("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        runDirected("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        runDirected("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        runDirected("divu by zero", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 2);
        runDirected("div by zero", 1'b1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 2);
        runDirected("div overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);

        // Annul at cycle 10 of a running divide.
        applyStimulus(1'b1, 1'b0, 32'd1000, 32'd3, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step();
            applyStimulus(1'b0, 1'b0, 32'd1000, 32'd3, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 32'd1000, 32'd3, 1'b1);
        step();
        checkOne("annul stall", {31'd0, obs_stall}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd1000, 32'd3, 1'b0);
        step();
        checkOne("annul busy", {31'd0, obs_busy}, 32'd0);
        checkOne("annul lo kept", obs_lo, 32'h8000_0000);
        checkOne("annul hi kept", obs_hi, 32'd0);
        valids = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (obs_valid) valids++;
        end
        checkOne("annul no valid", 32'(valids), 32'd0);
        runDirected("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        // Synchronous reset in cycle 5 of a running divide.
        applyStimulus(1'b1, 1'b1, 32'hFFFF_0000, 32'd5, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step();
            applyStimulus(1'b0, 1'b1, 32'hFFFF_0000, 32'd5, 1'b0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        checkOne("rst busy", {31'd0, obs_busy}, 32'd0);
        checkOne("rst stall", {31'd0, obs_stall}, 32'd0);
        checkOne("rst valid", {31'd0, obs_valid}, 32'd0);
        checkOne("rst hi", obs_hi, 32'd0);
        checkOne("rst lo", obs_lo, 32'd0);

        // Back-to-back: start held high, operands churn every cycle.
        valids = 0;
        for (int c = 0; c < 102; c++) begin
            applyStimulus(1'b1, 1'($urandom), $urandom, $urandom | 32'd1, 1'b0);
            step();
            if (obs_valid) valids++;
        end
        checkOne("back-to-back valids", 32'(valids), 32'd3);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        for (int c = 0; c < 40; c++) step();

        // Randomized traffic with biased corner operands, annuls and resets.
        for (int c = 0; c < 2500; c++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            applyStimulus(($urandom % 3) != 0, 1'($urandom), a, b, ($urandom % 40) == 0);
            rst = ($urandom % 400) == 0;
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
